// File: rtl/curr_block_feeder.sv
// Streams one 32x32 current block into the PE array as 512 pixel pairs using credit-limited
// memory reads and an in-order return FIFO, then commits the block with a change_curr/done handshake.
module curr_block_feeder #(
  parameter int DRAIN_CYC = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  cb_id,
  output logic        mem_rd_req,
  output logic [8:0]  mem_rd_addr,
  input  logic [15:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic [15:0] current_2pixels,
  output logic        in_curr_enable,
  output logic        change_curr,
  output logic [2:0]  CB_select,
  output logic        busy,
  output logic        done,
  output logic        err_unexp
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int AW = $clog2(MAX_OUTST);
  localparam logic [9:0] NPAIRS = 10'd512;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, COMMIT, DONE} state_t;

  state_t          state;
  logic [9:0]      req_cnt;
  logic [9:0]      beat_cnt;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   fifo_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [15:0]     fifo_mem [MAX_OUTST];
  logic [3:0]      drain_cnt;
  logic [OW:0]     credit_used;
  logic            issue;
  logic            ret_ok;
  logic            pop;

  // Reads in flight plus buffered pairs never exceed the FIFO depth, so returns always fit.
  assign credit_used = {1'b0, outst} + {1'b0, fifo_cnt};
  assign issue  = (state == FETCH) && (req_cnt < NPAIRS) && (credit_used < (OW+1)'(MAX_OUTST));
  assign ret_ok = mem_rd_valid && (outst != '0);
  assign pop    = (fifo_cnt != '0);

  always_ff @(posedge clk) begin
    if (ret_ok) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_cnt         <= '0;
      beat_cnt        <= '0;
      outst           <= '0;
      fifo_cnt        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      drain_cnt       <= '0;
      mem_rd_req      <= 1'b0;
      mem_rd_addr     <= '0;
      current_2pixels <= '0;
      in_curr_enable  <= 1'b0;
      change_curr     <= 1'b0;
      CB_select       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_unexp       <= 1'b0;
    end else begin
      mem_rd_req <= issue;
      if (issue) begin
        mem_rd_addr <= req_cnt[8:0];
        req_cnt     <= req_cnt + 10'd1;
      end

      outst    <= outst + OW'(issue) - OW'(ret_ok);
      fifo_cnt <= fifo_cnt + OW'(ret_ok) - OW'(pop);
      if (ret_ok) wr_ptr <= wr_ptr + AW'(1);

      in_curr_enable <= pop;
      if (pop) begin
        current_2pixels <= fifo_mem[rd_ptr];
        rd_ptr          <= rd_ptr + AW'(1);
        if (beat_cnt != NPAIRS) beat_cnt <= beat_cnt + 10'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            CB_select <= cb_id;
            busy      <= 1'b1;
            req_cnt   <= '0;
            beat_cnt  <= '0;
            outst     <= '0;
            err_unexp <= 1'b0;
          end
        end
        FETCH: begin
          // beat_cnt reaches 512 while the last beat is on the output, so this leaves right after it.
          if (beat_cnt == NPAIRS) begin
            if (DRAIN_CYC == 0) begin
              state       <= COMMIT;
              change_curr <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'(DRAIN_CYC - 1)) begin
            state       <= COMMIT;
            change_curr <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        COMMIT: begin
          change_curr <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Stray returns are dropped; the flag wins over the clear done by a same-cycle start.
      if (mem_rd_valid && (outst == '0)) err_unexp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_curr_block_feeder.sv
// Bench: two feeders (drain 2 and drain 0) share control inputs, each with its own in-order memory model.
module tb_curr_block_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cb_id = 3'd0;
  logic [15:0] rdata [2];
  logic [1:0]  rvalid = 2'b00;

  wire        req [2];
  wire [8:0]  addr [2];
  wire [15:0] pix [2];
  wire        en [2];
  wire        chg [2];
  wire [2:0]  sel [2];
  wire        busy [2];
  wire        done [2];
  wire        err [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int mk;
  int pend0[$];
  int pend1[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  int ret_cnt0 = 0;
  int ret_base;

  int beats0, beats1, dbad0, dbad1, selbad;
  int b512c0, b512c1, chg0, chg1, chgc0, chgc1;
  int done0, done1, donec0, donec1;
  int maxc, gaps, rq0, rstbad, ret_after, tmo;

  curr_block_feeder #(.DRAIN_CYC(2), .MAX_OUTST(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cb_id(cb_id),
    .mem_rd_req(req[0]), .mem_rd_addr(addr[0]), .mem_rd_data(rdata[0]), .mem_rd_valid(rvalid[0]),
    .current_2pixels(pix[0]), .in_curr_enable(en[0]), .change_curr(chg[0]), .CB_select(sel[0]),
    .busy(busy[0]), .done(done[0]), .err_unexp(err[0])
  );

  curr_block_feeder #(.DRAIN_CYC(0), .MAX_OUTST(4)) dut_d0 (
    .clk(clk), .rst(rst), .start(start), .cb_id(cb_id),
    .mem_rd_req(req[1]), .mem_rd_addr(addr[1]), .mem_rd_data(rdata[1]), .mem_rd_valid(rvalid[1]),
    .current_2pixels(pix[1]), .in_curr_enable(en[1]), .change_curr(chg[1]), .CB_select(sel[1]),
    .busy(busy[1]), .done(done[1]), .err_unexp(err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] patt(input int i, input logic [8:0] k);
    if (i == 1) return {k[7:0] ^ 8'hFF, k[7:0]};
    return 16'hA500 ^ {7'd0, k};
  endfunction

  // Memory: a request seen in cycle c returns in cycle c+lat, one return per cycle, held off during reset.
  always @(negedge clk) begin
    if (req[0] === 1'b1) pend0.push_back((cyc + lat) * 1024 + int'(addr[0]));
    if (req[1] === 1'b1) pend1.push_back((cyc + lat) * 1024 + int'(addr[1]));
    rvalid = 2'b00;
    if (!rst && pend0.size() > 0 && pend0[0] / 1024 <= cyc) begin
      mk = pend0.pop_front() % 1024;
      rdata[0] = patt(0, 9'(mk));
      rvalid[0] = 1'b1;
      ret_cnt0++;
    end
    if (!rst && pend1.size() > 0 && pend1[0] / 1024 <= cyc) begin
      mk = pend1.pop_front() % 1024;
      rdata[1] = patt(1, 9'(mk));
      rvalid[1] = 1'b1;
    end
  end

  task automatic run_op(input int lat_i, input logic [2:0] cb, input bit do_restart, input bit do_rst);
    bit restarted = 0;
    bit rst_hit = 0;
    bit fin = 0;
    int hold = 0;
    int tail = -1;
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < 512; k++) begin
      exp0.push_back(patt(0, 9'(k)));
      exp1.push_back(patt(1, 9'(k)));
    end
    beats0 = 0; beats1 = 0; dbad0 = 0; dbad1 = 0; selbad = 0;
    b512c0 = -1; b512c1 = -1; chg0 = 0; chg1 = 0; chgc0 = -1; chgc1 = -1;
    done0 = 0; done1 = 0; donec0 = -1; donec1 = -1;
    maxc = 0; gaps = 0; rq0 = 0; rstbad = 0; ret_after = 0; ret_base = ret_cnt0;
    lat = lat_i;
    @(negedge clk); #1;
    cb_id = cb;
    start = 1'b1;
    for (int n = 0; n < 8000 && !fin; n++) begin
      @(negedge clk); #1;
      start = 1'b0;
      cb_id = 3'($urandom_range(0, 7));
      if (req[0]) rq0++;
      if (en[0]) begin
        beats0++;
        if (exp0.size() == 0) dbad0++;
        else if (pix[0] !== exp0.pop_front()) dbad0++;
        if (sel[0] !== cb) selbad++;
        if (beats0 == 512) b512c0 = cyc;
      end
      if (en[1]) begin
        beats1++;
        if (exp1.size() == 0) dbad1++;
        else if (pix[1] !== exp1.pop_front()) dbad1++;
        if (beats1 == 512) b512c1 = cyc;
      end
      if (rq0 - beats0 > maxc) maxc = rq0 - beats0;
      if (busy[0] && beats0 > 0 && beats0 < 512 && !en[0]) gaps++;
      if (chg[0]) begin
        chg0++;
        chgc0 = cyc;
        if (sel[0] !== cb) selbad++;
      end
      if (chg[1]) begin chg1++; chgc1 = cyc; end
      if (done[0]) begin done0++; donec0 = cyc; end
      if (done[1]) begin done1++; donec1 = cyc; end
      if (do_restart && !restarted && beats0 >= 100) begin
        start = 1'b1;
        cb_id = 3'd2;
        restarted = 1;
      end
      if (do_rst && !rst_hit && beats0 >= 300) begin
        rst_hit = 1;
        rst = 1'b1;
        hold = 3;
        while (pend0.size() > 3) void'(pend0.pop_back());
        while (pend1.size() > 3) void'(pend1.pop_back());
      end else if (hold > 0) begin
        if ({pix[0], en[0], chg[0], sel[0], req[0], addr[0], busy[0], done[0], err[0]} !== 34'd0) rstbad++;
        hold--;
        if (hold == 0) begin
          rst = 1'b0;
          ret_base = ret_cnt0;
          tail = 40;
        end
      end
      if (tail < 0 && done0 > 0 && done1 > 0) tail = 5;
      if (tail > 0) begin
        tail--;
        fin = (tail == 0);
      end
    end
    tmo = fin ? 0 : 1;
    ret_after = ret_cnt0 - ret_base;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    cb_id = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({pix[i], en[i], chg[i], sel[i], req[i], addr[i], busy[i], done[i], err[i]} !== 34'd0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got %h expected 0", i,
                 {pix[i], en[i], chg[i], sel[i], req[i], addr[i], busy[i], done[i], err[i]});
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_wait();
    run_op(1, 3'd5, 1'b0, 1'b0);
    total++; if (tmo !== 0) begin bad++; $display("FAIL zw_timeout: got %0d expected 0", tmo); end
    total++; if (beats0 !== 512) begin bad++; $display("FAIL zw_beats: got %0d expected 512", beats0); end
    total++; if (dbad0 !== 0) begin bad++; $display("FAIL zw_data: got %0d wrong beats expected 0", dbad0); end
    total++; if (selbad !== 0) begin bad++; $display("FAIL zw_cb_select: got %0d wrong samples expected 0", selbad); end
    total++; if (chg0 !== 1) begin bad++; $display("FAIL zw_change_count: got %0d expected 1", chg0); end
    total++; if (chgc0 - b512c0 !== 3) begin bad++; $display("FAIL zw_change_timing: got %0d expected 3", chgc0 - b512c0); end
    total++; if (done0 !== 1) begin bad++; $display("FAIL zw_done_count: got %0d expected 1", done0); end
    total++; if (donec0 - chgc0 !== 1) begin bad++; $display("FAIL zw_done_timing: got %0d expected 1", donec0 - chgc0); end
    total++; if (busy[0] !== 1'b0 || err[0] !== 1'b0) begin bad++; $display("FAIL zw_idle_flags: got busy=%b err=%b expected 0 0", busy[0], err[0]); end
  endtask

  task automatic test_latency();
    run_op(6, 3'd3, 1'b0, 1'b0);
    total++; if (tmo !== 0) begin bad++; $display("FAIL lat_timeout: got %0d expected 0", tmo); end
    total++; if (beats0 !== 512) begin bad++; $display("FAIL lat_beats: got %0d expected 512", beats0); end
    total++; if (dbad0 !== 0) begin bad++; $display("FAIL lat_order: got %0d wrong beats expected 0", dbad0); end
    total++; if (maxc > 4) begin bad++; $display("FAIL lat_credit: got %0d expected at most 4", maxc); end
    total++; if (gaps == 0) begin bad++; $display("FAIL lat_gaps: got %0d gap cycles expected some", gaps); end
    total++; if (done0 !== 1) begin bad++; $display("FAIL lat_done_count: got %0d expected 1", done0); end
  endtask

  task automatic test_restart();
    run_op(1, 3'd6, 1'b1, 1'b0);
    total++; if (selbad !== 0) begin bad++; $display("FAIL rs_cb_select: got %0d wrong samples expected 0", selbad); end
    total++; if (sel[0] !== 3'd6) begin bad++; $display("FAIL rs_cb_final: got %0d expected 6", sel[0]); end
    total++; if (beats0 !== 512) begin bad++; $display("FAIL rs_beats: got %0d expected 512", beats0); end
    total++; if (done0 !== 1) begin bad++; $display("FAIL rs_done_count: got %0d expected 1", done0); end
  endtask

  task automatic test_reset_mid();
    run_op(6, 3'd4, 1'b0, 1'b1);
    total++; if (rstbad !== 0) begin bad++; $display("FAIL rm_outputs_in_reset: got %0d nonzero cycles expected 0", rstbad); end
    total++; if (chg0 !== 0) begin bad++; $display("FAIL rm_no_change: got %0d expected 0", chg0); end
    total++; if (done0 !== 0) begin bad++; $display("FAIL rm_no_done: got %0d expected 0", done0); end
    total++; if (ret_after !== 3) begin bad++; $display("FAIL rm_late_returns: got %0d expected 3", ret_after); end
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL rm_err_set: got %b expected 1", err[0]); end
    run_op(1, 3'd1, 1'b0, 1'b0);
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL rm_err_cleared: got %b expected 0", err[0]); end
    total++; if (beats0 !== 512 || dbad0 !== 0) begin bad++; $display("FAIL rm_rerun_data: got beats=%0d bad=%0d expected 512 0", beats0, dbad0); end
    total++; if (done0 !== 1) begin bad++; $display("FAIL rm_rerun_done: got %0d expected 1", done0); end
  endtask

  task automatic test_drain0();
    run_op(1, 3'd7, 1'b0, 1'b0);
    total++; if (beats1 !== 512) begin bad++; $display("FAIL d0_beats: got %0d expected 512", beats1); end
    total++; if (dbad1 !== 0) begin bad++; $display("FAIL d0_pattern: got %0d wrong beats expected 0", dbad1); end
    total++; if (chgc1 - b512c1 !== 1) begin bad++; $display("FAIL d0_change_timing: got %0d expected 1", chgc1 - b512c1); end
    total++; if (done1 !== 1 || donec1 - chgc1 !== 1) begin bad++; $display("FAIL d0_done: got count=%0d delay=%0d expected 1 1", done1, donec1 - chgc1); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_restart();
    test_reset_mid();
    test_drain0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/curr_block_feeder.md
CURR_BLOCK_FEEDER -- requirements
Module: curr_block_feeder

Interface
REQ-001 Parameter: DRAIN_CYC, 2, idle cycles between the last pixel-pair beat and the change_curr pulse (range 0..15).
REQ-002 Parameter: MAX_OUTST, 4, FIFO depth and the limit on outstanding memory reads plus buffered pairs (power of 2, 2..8).
REQ-003 Port: clk  in  1  single clock; every flop is clocked on the rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: start  in  1  one-cycle request to load one 32x32 current block.
REQ-006 Port: cb_id  in  3  target CB register (0..7); sampled when start is accepted.
REQ-007 Port: mem_rd_req  out  1  read request strobe, one pixel pair per request.
REQ-008 Port: mem_rd_addr  out  9  pair index k (0..511); row = k/16, column pair = k%16.
REQ-009 Port: mem_rd_data  in  16  returned pair; bits [7:0] = even (left) pixel, bits [15:8] = odd pixel.
REQ-010 Port: mem_rd_valid  in  1  mem_rd_data valid; returns arrive in request order, latency >= 1 cycle.
REQ-011 Port: current_2pixels  out  16  pixel pair to the PE array, same byte order as mem_rd_data.
REQ-012 Port: in_curr_enable  out  1  current_2pixels valid this cycle.
REQ-013 Port: change_curr  out  1  one-cycle commit of the loaded block into the PE array.
REQ-014 Port: CB_select  out  3  latched cb_id, driven for the whole operation.
REQ-015 Port: busy  out  1  high from start acceptance through the done cycle.
REQ-016 Port: done  out  1  one-cycle pulse on the cycle after change_curr.
REQ-017 Port: err_unexp  out  1  sticky flag: mem_rd_valid seen with no read outstanding.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, DRAIN, COMMIT, DONE.
REQ-019 IDLE->FETCH on start: latch cb_id into CB_select, clear req_cnt, beat_cnt, outstanding count and err_unexp; raise busy.
REQ-020 In FETCH, mem_rd_req=1 with mem_rd_addr=req_cnt when req_cnt<512 and (outstanding + FIFO occupancy) < MAX_OUTST; req_cnt then increments.
REQ-021 A mem_rd_valid with outstanding>0 SHALL push mem_rd_data into the FIFO and decrement outstanding; the same-cycle request and return SHALL both be counted.
REQ-022 The FIFO SHALL never overflow; the credit rule in REQ-020 guarantees this, and no backpressure to memory exists.
REQ-023 Each cycle the FIFO is non-empty, the feeder SHALL pop the head into registered current_2pixels with in_curr_enable=1 on the next cycle (1-cycle latency), otherwise in_curr_enable=0 and current_2pixels holds its value.
REQ-024 Gaps in in_curr_enable are legal; exactly 512 enable beats SHALL occur per operation, in address order 0..511.
REQ-025 FETCH->DRAIN in the cycle after the 512th enable beat; DRAIN SHALL last DRAIN_CYC cycles (0 = skip DRAIN).
REQ-026 COMMIT SHALL last one cycle with change_curr=1; DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-027 start while busy SHALL be ignored; cb_id changes mid-operation SHALL not affect CB_select.
REQ-028 mem_rd_valid with outstanding=0, in any state, SHALL be dropped and SHALL set err_unexp.
REQ-029 Counters: req_cnt and beat_cnt 10 bits, saturating at 512; outstanding width ceil(log2(MAX_OUTST+1)).

Reset
REQ-030 rst SHALL force IDLE, empty the FIFO, zero all counters, and drive current_2pixels=0, in_curr_enable=0, change_curr=0, CB_select=0, mem_rd_req=0, mem_rd_addr=0, busy=0, done=0, err_unexp=0.
REQ-031 Reset mid-operation SHALL abort with no change_curr; returns still in flight after reset release SHALL be treated per REQ-028.

Verification
REQ-032 Zero-wait memory (latency 1), start with cb_id=5 -> 512 enable beats, the k-th carrying pair k; change_curr at beat512+1+DRAIN_CYC with CB_select=5; done on the cycle after change_curr.
REQ-033 Memory latency 6 -> outstanding+occupancy never exceeds 4, enable shows gaps, beat count still 512, order preserved.
REQ-034 start pulsed again at beat 100 with cb_id=2 -> ignored; CB_select stays at the original value; exactly one done.
REQ-035 rst asserted at beat 300 with 3 reads outstanding, those 3 returns delivered after release -> all outputs 0 during reset, no change_curr, err_unexp=1, next start clears it and completes normally.
REQ-036 DRAIN_CYC=0, data pattern pair k = {k[7:0]^8'hFF, k[7:0]} -> change_curr on the cycle after beat 512 and current_2pixels bytes match the pattern at every beat.
